// File: rtl/loctag_mac_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : loctag_mac_sched_if
// Brief    : Handshake bundle between the reader front-end/modulator and the
//            LocTag slotted-ALOHA MAC scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface loctag_mac_sched_if;
    logic       frame_start;
    logic [2:0] q_in;
    logic       slot_tick;
    logic       reply_done;
    logic       ack;
    logic       rearm;
    logic       tx_grant;
    logic       acked;
    logic [7:0] slot_cnt;
    logic [7:0] collision_cnt;
    logic [2:0] state_o;

    modport master (
        output frame_start, q_in, slot_tick, reply_done, ack, rearm,
        input  tx_grant, acked, slot_cnt, collision_cnt, state_o
    );

    modport slave (
        input  frame_start, q_in, slot_tick, reply_done, ack, rearm,
        output tx_grant, acked, slot_cnt, collision_cnt, state_o
    );
endinterface
`default_nettype wire

// File: rtl/loctag_mac_sched.sv
`default_nettype none
// ============================================================================
// Module   : loctag_mac_sched
// Brief    : Framed slotted-ALOHA scheduler; picks the reply slot from an LFSR
//            and grants the modulator, re-drawing after a lost acknowledgement.
// Revision : 1.0 - initial release
// ============================================================================
module loctag_mac_sched #(
    parameter int          Q_MAX          = 4,
    parameter int          CLK_PER_US     = 50,
    parameter int          ACK_TIMEOUT_US = 200,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    loctag_mac_sched_if.slave mac
);

    localparam int          c_timeout_cyc = ACK_TIMEOUT_US * CLK_PER_US;
    localparam int          c_tmr_w       = (c_timeout_cyc < 2) ? 1 : $clog2(c_timeout_cyc + 1);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(c_timeout_cyc - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_max  = '1;
    localparam logic [2:0]  c_q_max       = (Q_MAX > 7) ? 3'd7 : 3'(Q_MAX);
    localparam logic [15:0] c_seed        = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] c_lfsr_taps   = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARB      = 3'd1,
        S_REPLY    = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_ACKED    = 3'd4
    } state_t;

    state_t               r_state;
    logic [15:0]          r_lfsr;
    logic [2:0]           r_q;
    logic [7:0]           r_slot_cnt;
    logic [7:0]           r_coll;
    logic [c_tmr_w-1:0]   r_timer;
    logic                 r_tx_grant;
    logic                 r_acked;

    state_t               w_state_nxt;
    logic [7:0]           w_slot_nxt;
    logic [7:0]           w_coll_nxt;
    logic [2:0]           w_q_nxt;
    logic [c_tmr_w-1:0]   w_timer_nxt;
    logic [15:0]          w_lfsr_nxt;
    logic [2:0]           w_q_eff;
    logic [7:0]           w_draw_new;
    logic [7:0]           w_draw_old;
    logic [7:0]           w_draw;
    logic                 w_do_draw;
    logic                 w_fs_ok;
    logic                 w_timeout;

    function automatic logic [7:0] f_mask(input logic [2:0] q);
        return ~(8'hFF << q);
    endfunction

    assign w_q_eff    = (mac.q_in > c_q_max) ? c_q_max : mac.q_in;
    assign w_draw_new = r_lfsr[7:0] & f_mask(w_q_eff);
    assign w_draw_old = r_lfsr[7:0] & f_mask(r_q);
    assign w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_lfsr_taps) : (r_lfsr >> 1);
    assign w_timeout  = (r_state == S_WAIT_ACK) && (r_timer == c_tmr_last);
    assign w_fs_ok    = mac.frame_start &&
                        (r_state inside {S_IDLE, S_ARB, S_REPLY, S_WAIT_ACK});

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot_cnt;
        w_coll_nxt  = r_coll;
        w_q_nxt     = r_q;
        w_do_draw   = 1'b0;
        w_draw      = w_draw_old;

        // A new frame overrides everything except ACKED; it also aborts a grant.
        if (w_fs_ok) begin
            w_q_nxt   = w_q_eff;
            w_draw    = w_draw_new;
            w_do_draw = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_ARB: begin
                    if (mac.slot_tick) begin
                        w_slot_nxt = r_slot_cnt - 8'd1;
                        if (r_slot_cnt == 8'd1) begin
                            w_state_nxt = S_REPLY;
                        end
                    end
                end
                S_REPLY: begin
                    if (mac.reply_done || mac.slot_tick) begin
                        w_state_nxt = S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (mac.ack) begin
                        w_state_nxt = S_ACKED;
                    end else if (mac.slot_tick || w_timeout) begin
                        if (r_coll != 8'hFF) begin
                            w_coll_nxt = r_coll + 8'd1;
                        end
                        w_do_draw = 1'b1;
                    end
                end
                S_ACKED: begin
                    if (mac.rearm) begin
                        w_state_nxt = S_IDLE;
                        w_slot_nxt  = 8'd0;
                        w_coll_nxt  = 8'd0;
                        w_q_nxt     = 3'd0;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        if (w_do_draw) begin
            if (w_draw == 8'd0) begin
                w_state_nxt = S_REPLY;
                w_slot_nxt  = 8'd0;
            end else begin
                w_state_nxt = S_ARB;
                w_slot_nxt  = w_draw;
            end
        end
    end

    // Timer restarts whenever WAIT_ACK is entered and saturates rather than wraps.
    always_comb begin
        w_timer_nxt = '0;
        if ((r_state == S_WAIT_ACK) && (w_state_nxt == S_WAIT_ACK)) begin
            w_timer_nxt = (r_timer == c_tmr_max) ? r_timer : r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_lfsr     <= c_seed;
            r_q        <= 3'd0;
            r_slot_cnt <= 8'd0;
            r_coll     <= 8'd0;
            r_timer    <= '0;
            r_tx_grant <= 1'b0;
            r_acked    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lfsr     <= w_lfsr_nxt;
            r_q        <= w_q_nxt;
            r_slot_cnt <= w_slot_nxt;
            r_coll     <= w_coll_nxt;
            r_timer    <= w_timer_nxt;
            r_tx_grant <= (w_state_nxt == S_REPLY);
            r_acked    <= (w_state_nxt == S_ACKED);
        end
    end

    assign mac.tx_grant      = r_tx_grant;
    assign mac.acked         = r_acked;
    assign mac.slot_cnt      = r_slot_cnt;
    assign mac.collision_cnt = r_coll;
    assign mac.state_o       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_loctag_mac_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_loctag_mac_sched
// Brief    : Directed bench for loctag_mac_sched with a slot-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_loctag_mac_sched;

    localparam int c_q_max   = 4;
    localparam int c_timeout = 2 * 50;

    localparam int M_IDLE = 0, M_ARB = 1, M_REPLY = 2, M_WAIT = 3, M_ACKED = 4;

    logic clk;
    logic reset;
    loctag_mac_sched_if lif();

    loctag_mac_sched #(
        .Q_MAX          (c_q_max),
        .CLK_PER_US     (50),
        .ACK_TIMEOUT_US (2),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mac   (lif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: tag behaviour expressed as slots remaining and cycles waited.
    int          m_state = 0;
    int          m_slots = 0;
    int          m_coll  = 0;
    int          m_q     = 0;
    int          m_wait  = 0;
    logic [15:0] m_lfsr  = 16'hACE1;
    bit          m_valid = 1'b0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    task automatic model_draw(input logic [15:0] v);
        int d;
        d = int'(v[7:0]) % (1 << m_q);
        if (d == 0) begin
            m_state = M_REPLY;
            m_slots = 0;
        end else begin
            m_state = M_ARB;
            m_slots = d;
        end
    endtask

    always @(posedge clk) begin : model
        logic [15:0] cur;
        if (reset) begin
            m_state = M_IDLE; m_slots = 0; m_coll = 0; m_q = 0; m_wait = 0;
            m_lfsr  = 16'hACE1;
            m_valid = 1'b1;
        end else begin
            cur = m_lfsr;
            if (lif.frame_start && m_state != M_ACKED) begin
                m_q = (int'(lif.q_in) > c_q_max) ? c_q_max : int'(lif.q_in);
                model_draw(cur);
            end else begin
                case (m_state)
                    M_ARB: if (lif.slot_tick) begin
                        m_slots = m_slots - 1;
                        if (m_slots == 0) m_state = M_REPLY;
                    end
                    M_REPLY: if (lif.reply_done || lif.slot_tick) begin
                        m_state = M_WAIT;
                        m_wait  = 0;
                    end
                    M_WAIT: begin
                        m_wait = m_wait + 1;
                        if (lif.ack) begin
                            m_state = M_ACKED;
                        end else if (lif.slot_tick || m_wait == c_timeout) begin
                            if (m_coll < 255) m_coll = m_coll + 1;
                            model_draw(cur);
                        end
                    end
                    M_ACKED: if (lif.rearm) begin
                        m_state = M_IDLE; m_slots = 0; m_coll = 0; m_q = 0;
                    end
                    default: ;
                endcase
            end
            m_lfsr = lfsr_next(cur);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            n_checks++;
            if (lif.tx_grant !== (m_state == M_REPLY) || lif.acked !== (m_state == M_ACKED) ||
                lif.slot_cnt !== 8'(m_slots) || lif.collision_cnt !== 8'(m_coll) ||
                lif.state_o !== 3'(m_state)) begin
                n_errors++;
                $display("FAIL model_cmp t=%0t got st=%0d gr=%0b ak=%0b sc=%0d cc=%0d want st=%0d gr=%0b ak=%0b sc=%0d cc=%0d",
                         $time, lif.state_o, lif.tx_grant, lif.acked, lif.slot_cnt, lif.collision_cnt,
                         m_state, (m_state == M_REPLY), (m_state == M_ACKED), m_slots, m_coll);
            end
        end
    end

    task automatic chk(input string name, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        lif.frame_start = 1'b0;
        lif.slot_tick   = 1'b0;
        lif.reply_done  = 1'b0;
        lif.ack         = 1'b0;
        lif.rearm       = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int n;
        int dmax;
        reset           = 1'b1;
        lif.frame_start = 1'b0;
        lif.q_in        = 3'd0;
        lif.slot_tick   = 1'b0;
        lif.reply_done  = 1'b0;
        lif.ack         = 1'b0;
        lif.rearm       = 1'b0;
        steps(3);
        chk("reset_state", int'(lif.state_o), 0);
        chk("reset_grant", int'(lif.tx_grant), 0);
        chk("reset_coll", int'(lif.collision_cnt), 0);
        reset = 1'b0;

        // Stray ticks and acks while idle must do nothing.
        for (int i = 0; i < 20; i++) begin
            lif.slot_tick = 1'b1;
            lif.ack       = 1'b1;
            step();
        end
        chk("idle_state", int'(lif.state_o), 0);
        chk("idle_outs", int'({lif.tx_grant, lif.acked, lif.slot_cnt}), 0);

        // q=0: immediate grant, reply, ack, ignored frame, rearm.
        lif.q_in = 3'd0;
        lif.frame_start = 1'b1; step();
        chk("q0_grant", int'(lif.tx_grant), 1);
        steps(19);
        chk("q0_grant_held", int'(lif.tx_grant), 1);
        lif.reply_done = 1'b1; step();
        chk("rd_state", int'(lif.state_o), 3);
        chk("rd_grant", int'(lif.tx_grant), 0);
        steps(9);
        lif.ack = 1'b1; step();
        chk("ack_acked", int'(lif.acked), 1);
        steps(9);
        lif.frame_start = 1'b1; step();
        chk("acked_ignores_frame", int'(lif.state_o), 4);
        steps(9);
        lif.rearm = 1'b1; step();
        chk("rearm_idle", int'(lif.state_o), 0);

        // q=3: count down the drawn number of slots.
        lif.q_in = 3'd3;
        for (int t = 0; t < 8; t++) begin
            lif.frame_start = 1'b1; step();
            if (m_slots > 0) break;
        end
        n = m_slots;
        chk("q3_slot_vs_model", int'(lif.slot_cnt), n);
        chk("q3_draw_le7", int'(lif.slot_cnt <= 8'd7), 1);
        for (int i = 1; i <= n; i++) begin
            step();
            chk("q3_no_early_grant", int'(lif.tx_grant), 0);
            lif.slot_tick = 1'b1; step();
            chk("q3_grant_after_last", int'(lif.tx_grant), (i == n) ? 1 : 0);
        end
        lif.reply_done = 1'b1; step();
        lif.ack = 1'b1; step();
        lif.rearm = 1'b1; step();

        // Lost acknowledgement: timeout after exactly 100 cycles.
        lif.q_in = 3'd0;
        lif.frame_start = 1'b1; step();
        lif.reply_done = 1'b1; step();
        steps(99);
        chk("to_not_yet_state", int'(lif.state_o), 3);
        chk("to_not_yet_coll", int'(lif.collision_cnt), 0);
        step();
        chk("to_coll", int'(lif.collision_cnt), 1);
        chk("to_back_reply", int'(lif.state_o), 2);

        // ack and slot_tick together: ack wins.
        lif.reply_done = 1'b1; step();
        steps(3);
        lif.ack = 1'b1; lif.slot_tick = 1'b1; step();
        chk("ack_tick_state", int'(lif.state_o), 4);
        chk("ack_tick_coll", int'(lif.collision_cnt), 1);
        lif.rearm = 1'b1; step();
        chk("rearm_clears_coll", int'(lif.collision_cnt), 0);

        // Collision counter saturation.
        lif.frame_start = 1'b1; step();
        for (int i = 0; i < 300; i++) begin
            lif.reply_done = 1'b1; step();
            steps(c_timeout);
        end
        chk("coll_saturates", int'(lif.collision_cnt), 255);
        chk("sat_state_reply", int'(lif.state_o), 2);

        reset = 1'b1; step();
        chk("reset_in_reply_grant", int'(lif.tx_grant), 0);
        chk("reset_in_reply_state", int'(lif.state_o), 0);
        reset = 1'b0;

        // q=7 clamps to Q_MAX=4: draws span 0..15.
        lif.q_in = 3'd7;
        dmax = 0;
        for (int i = 0; i < 1000; i++) begin
            lif.frame_start = 1'b1; step();
            if (int'(lif.slot_cnt) > dmax) dmax = int'(lif.slot_cnt);
            steps($urandom_range(0, 3));
        end
        chk("q7_max_le15", int'(dmax <= 15), 1);
        chk("q7_reaches_8plus", int'(dmax >= 8), 1);

        steps(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
